mem_access: RTL and testbench
=============================

# mem_access

Memory-stage access controller of the 16-bit pipeline: the producer side of the MEM/WB interface, generating `memres_o` for the MEM/WB register. It turns the EX/MEM load/store request into multi-cycle RAM1 SRAM bus cycles and UART register accesses. While an access is in flight it stalls the pipeline, so the MEM/WB register captures valid data on the edge where the stall drops.

## Interface
- No parameters; address map and timing constants live in `cpu_pkg`.
- `CLK` in 1: clock; all state changes on posedge.
- `RST` in 1: reset, asynchronous, active-low.
- `memread_i` in 1: load request from EX/MEM.
- `memwrite_i` in 1: store request from EX/MEM.
- `addr_i` in 16: word address.
- `wdata_i` in 16: store data.
- `memres_o` out 16: load result, feeds MEM/WB `memres_i`.
- `stall_o` out 1: freeze IF/ID/EX/MEM while high.
- `ram_addr` out 18: SRAM address, `{2'b00, addr_i}`.
- `ram_data` inout 16: SRAM data bus.
- `ram_en_n` / `ram_oe_n` / `ram_we_n` out 1 each: SRAM strobes, active-low.
- `uart_rdn` / `uart_wrn` out 1 each: UART read/write strobes, active-low.
- `uart_data_ready`, `uart_tbre`, `uart_tsre` in 1 each: UART status.

## Operation
- States: IDLE, RD, WR_LO, WR_HI, URD, UWR_LO, UWR_HI, DONE.
- Request means `memread_i` or `memwrite_i` is high. If both are high, the write wins.
- Address decode:
  - 0xBF00: UART data.
  - 0xBF01: UART status.
  - All other addresses: SRAM.
- SRAM read:
  - IDLE: drive address, `ram_en_n=0`, `ram_oe_n=0`, `stall_o=1`, go to RD.
  - RD: latch `ram_data` into `memres_o`, go to DONE.
- SRAM write:
  - IDLE: drive address and data, `ram_en_n=0`, go to WR_LO.
  - WR_LO: `ram_we_n=0`, go to WR_HI.
  - WR_HI: `ram_we_n=1`, data still driven, go to DONE.
- UART data read (0xBF00): IDLE → URD with `uart_rdn=0`. In URD, latch `{8'h00, ram_data[7:0]}`, go to DONE.
- UART write (0xBF00): data driven from IDLE. UWR_LO has `uart_wrn=0`, UWR_HI has `uart_wrn=1`, then DONE.
- UART status read (0xBF01):
  - Single cycle, no stall.
  - `memres_o = {14'b0, uart_data_ready, uart_tbre & uart_tsre}`, combinational in IDLE.
  - Stores to 0xBF01 are ignored, no stall.
- DONE: all strobes high, bus high-Z, `stall_o=0`, return to IDLE.
- `ram_data` is driven only during write states; otherwise high-Z.
- SRAM and UART are never strobed in the same cycle.
- With no request, `memres_o` holds its last value.

## Timing
- Reset values:
  - `stall_o=0`, `memres_o=16'h0000`.
  - `ram_en_n`, `ram_oe_n`, `ram_we_n`, `uart_rdn`, `uart_wrn` all 1.
  - `ram_data` high-Z, state IDLE.
- `stall_o` is high combinationally in IDLE when a request needs more than one cycle, and stays high in every state except DONE.
- Latency, counting from the IDLE cycle through DONE:
  - SRAM read: 3 cycles.
  - SRAM write: 4 cycles.
  - UART data read: 3 cycles.
  - UART write: 4 cycles.
  - UART status: 1 cycle.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. There are no dead cycles beyond DONE.
- Request inputs are held stable by the stall. Only the IDLE-cycle sample is used; later changes are ignored.
- Reset mid-access: all strobes deassert and the bus releases immediately (asynchronously). No partial write pulse is completed.

## Configuration
- `MEM_ACCESS_UART_EN`
  - Defined: UART decode, UART states and `uart_*` ports are active.
  - Undefined: 0xBF00/0xBF01 decode as SRAM, `uart_rdn`/`uart_wrn` are tied to 1, and the UART states are not built.

## Structure
- `cpu_pkg` holds:
  - State enum.
  - `UART_DATA_ADDR` (0xBF00) and `UART_STAT_ADDR` (0xBF01).
  - `REG_NONE` (4'b1111).
- One sub-module, `uart_port`: decode, status word and `rdn`/`wrn` sequencing. It is instantiated only under the macro.

## Test plan
- Reset: hold `RST=0` with `memread_i=1` → all strobes 1, bus Z, `stall_o=0`, `memres_o=0`.
- SRAM read, addr 0x1234, SRAM model returns 0xBEEF → `stall_o` high 2 cycles, `memres_o=0xBEEF` in DONE, `ram_addr=0x01234`.
- SRAM write, 0x0040 ← 0xA5A5 → exactly one `ram_we_n` low cycle with data stable the cycle before and after; readback = 0xA5A5.
- UART status read, `data_ready=1`, `tbre=tsre=1` → `memres_o=0x0003` same cycle, `stall_o=0`.
- UART write 0x0041 → one `uart_wrn` low cycle, then DONE; with macro undefined, the same access hits SRAM instead.
- `RST` pulled low during WR_LO → `ram_we_n=1` and bus Z immediately, state IDLE after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory stage: FSM states, the load/store
// request bundle and the UART register addresses.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE, RD, WR_LO, WR_HI, URD, UWR_LO, UWR_HI, DONE
  } mem_state_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
  localparam logic [3:0]  REG_NONE       = 4'b1111;

endpackage

// File: rtl/mem_access_uart_port.sv
// UART side of the memory stage: address decode, status word and the
// active-low read/write strobes. Only built when MEM_ACCESS_UART_EN is defined.
module uart_port
  import cpu_pkg::*;
(
  input  logic        RST,
  input  mem_state_e  state,
  input  logic        rd_req,
  input  logic [15:0] addr_i,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre,
  output logic        data_hit,
  output logic        stat_hit,
  output logic [15:0] stat_word,
  output logic        uart_rdn,
  output logic        uart_wrn
);

  assign data_hit  = (addr_i == UART_DATA_ADDR);
  assign stat_hit  = (addr_i == UART_STAT_ADDR);
  assign stat_word = {14'b0, uart_data_ready, uart_tbre & uart_tsre};

  // Read strobe opens in the request cycle; the write strobe is a one-cycle pulse
  // framed by data setup (IDLE) and hold (UWR_HI). Reset releases both at once.
  assign uart_rdn = !(RST && ((state == IDLE && rd_req && data_hit) || state == URD));
  assign uart_wrn = !(RST && state == UWR_LO);

endmodule

// File: rtl/mem_access.sv
// Memory-stage access controller: sequences SRAM and UART bus cycles for
// EX/MEM loads/stores and stalls the pipeline while one is in flight.
// UART decode is present only when MEM_ACCESS_UART_EN is defined.
module mem_access
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] memres_o,
  output logic        stall_o,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  mem_state_e  state, state_nxt;
  mem_req_t    req;
  logic        data_hit, stat_hit, bus_drv;
  logic [15:0] stat_word, memres_q, addr_q, wdata_q, bus_dout;

  // Store wins when both request lines are high.
  assign req = '{rd: memread_i & ~memwrite_i, wr: memwrite_i, addr: addr_i, wdata: wdata_i};

`ifdef MEM_ACCESS_UART_EN
  uart_port u_uart (
    .RST(RST), .state(state), .rd_req(req.rd), .addr_i(req.addr),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .data_hit(data_hit), .stat_hit(stat_hit), .stat_word(stat_word),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn)
  );
`else
  logic unused_uart;
  assign unused_uart = ^{uart_data_ready, uart_tbre, uart_tsre};
  assign data_hit  = 1'b0;
  assign stat_hit  = 1'b0;
  assign stat_word = 16'h0000;
  assign uart_rdn  = 1'b1;
  assign uart_wrn  = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else      state <= state_nxt;

  // Only the IDLE-cycle request is used for the rest of the access.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      memres_q <= 16'h0000;
    end else begin
      if (state == IDLE) begin
        addr_q  <= req.addr;
        wdata_q <= req.wdata;
      end
      case (state)
        IDLE:    if (req.rd && stat_hit) memres_q <= stat_word;
        RD:      memres_q <= ram_data;
`ifdef MEM_ACCESS_UART_EN
        URD:     memres_q <= {8'h00, ram_data[7:0]};
`endif
        default: ;
      endcase
    end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req.wr) begin
          if (!stat_hit) state_nxt = data_hit ? UWR_LO : WR_LO;
        end else if (req.rd) begin
          if (!stat_hit) state_nxt = data_hit ? URD : RD;
        end
      end
      RD:      state_nxt = DONE;
      WR_LO:   state_nxt = WR_HI;
      WR_HI:   state_nxt = DONE;
`ifdef MEM_ACCESS_UART_EN
      URD:     state_nxt = DONE;
      UWR_LO:  state_nxt = UWR_HI;
      UWR_HI:  state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by RST so a reset mid-access releases the bus immediately.
  always_comb begin
    ram_en_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    stall_o  = 1'b0;
    bus_drv  = 1'b0;
    if (RST) begin
      case (state)
        IDLE: begin
          if (req.wr && !stat_hit) begin
            stall_o  = 1'b1;
            bus_drv  = 1'b1;
            ram_en_n = data_hit;
          end else if (req.rd && !stat_hit) begin
            stall_o  = 1'b1;
            ram_en_n = data_hit;
            ram_oe_n = data_hit;
          end
        end
        RD:    begin stall_o = 1'b1; ram_en_n = 1'b0; ram_oe_n = 1'b0; end
        WR_LO: begin stall_o = 1'b1; ram_en_n = 1'b0; ram_we_n = 1'b0; bus_drv = 1'b1; end
        WR_HI: begin stall_o = 1'b1; ram_en_n = 1'b0; bus_drv = 1'b1; end
`ifdef MEM_ACCESS_UART_EN
        URD:    stall_o = 1'b1;
        UWR_LO: begin stall_o = 1'b1; bus_drv = 1'b1; end
        UWR_HI: begin stall_o = 1'b1; bus_drv = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  assign ram_addr = {2'b00, (state == IDLE) ? req.addr : addr_q};
  assign bus_dout = (state == IDLE) ? req.wdata : wdata_q;
  assign ram_data = bus_drv ? bus_dout : 16'hzzzz;
  assign memres_o = (RST && state == IDLE && req.rd && stat_hit) ? stat_word : memres_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: SRAM/UART device models on the shared bus, a
// per-access behavioural model producing cycle expectations, and literal checks.
module tb_mem_access;

`ifdef MEM_ACCESS_UART_EN
  localparam bit UART = 1'b1;
`else
  localparam bit UART = 1'b0;
`endif

  logic        CLK = 1'b0, RST = 1'b0;
  logic        memread_i = 1'b0, memwrite_i = 1'b0;
  logic [15:0] addr_i = '0, wdata_i = '0;
  logic [15:0] memres_o;
  logic        stall_o;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;

  mem_access dut (
    .CLK(CLK), .RST(RST), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .memres_o(memres_o), .stall_o(stall_o),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en_n(ram_en_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .uart_rdn(uart_rdn),
    .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- device models ----------------
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  logic [15:0] sram [65536];
  bit          wflag [65536];
  int          we_cnt = 0, wrn_cnt = 0;
  logic [7:0]  uart_rx = 8'h5C, uart_tx = 8'h00;
  logic        probe_force = 1'b0, probe;
  logic        tb_drv;
  logic [15:0] tb_val;

  always @(posedge CLK) begin
    if (RST && !ram_en_n && !ram_we_n) begin
      sram[ram_addr[15:0]]  <= ram_data;
      wflag[ram_addr[15:0]] <= 1'b1;
      we_cnt                <= we_cnt + 1;
    end
    if (RST && !uart_wrn) begin
      uart_tx <= ram_data[7:0];
      wrn_cnt <= wrn_cnt + 1;
    end
  end

  always_comb begin
    tb_drv = 1'b0;
    tb_val = 16'h0000;
    if (!ram_en_n && !ram_oe_n) begin
      tb_drv = 1'b1;
      tb_val = wflag[ram_addr[15:0]] ? sram[ram_addr[15:0]] : init_val(ram_addr[15:0]);
    end else if (!uart_rdn) begin
      tb_drv = 1'b1;
      tb_val = {8'hAB, uart_rx};
    end else if (probe) begin
      tb_drv = 1'b1;
    end
  end
  assign ram_data = tb_drv ? tb_val : 16'hzzzz;

  // ---------------- behavioural model ----------------
  logic [15:0] mdl [logic [15:0]];
  logic [15:0] last_res = 16'h0000;
  logic        e_valid = 1'b0, e_stall, e_en, e_oe, e_we, e_rdn, e_wrn, e_busdrv;
  logic [15:0] e_res, e_bus;
  logic [17:0] e_addr;

  assign probe = probe_force | (e_valid & ~e_busdrv);

  function automatic logic [15:0] mdl_rd(input logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : init_val(a);
  endfunction

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  // kind: 0 none/ignored, 1 sram rd, 2 sram wr, 3 uart rd, 4 uart wr, 5 status rd
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic dr, input logic tb, input logic ts);
    int kind, len;
    logic udat, ustat;
    logic [15:0] newres;
    memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = d;
    uart_data_ready = dr; uart_tbre = tb; uart_tsre = ts;
    udat  = UART && (a == 16'hBF00);
    ustat = UART && (a == 16'hBF01);
    if (wr)      kind = ustat ? 0 : (udat ? 4 : 2);
    else if (rd) kind = ustat ? 5 : (udat ? 3 : 1);
    else         kind = 0;
    len = (kind == 2 || kind == 4) ? 4 : (kind == 1 || kind == 3) ? 3 : 1;
    case (kind)
      1:       newres = mdl_rd(a);
      3:       newres = {8'h00, uart_rx};
      5:       newres = {14'b0, dr, tb & ts};
      default: newres = last_res;
    endcase
    for (int k = 0; k < len; k++) begin
      e_stall  = (k < len - 1);
      e_en     = !((kind == 1 || kind == 2) && k < len - 1);
      e_oe     = !(kind == 1 && k < 2);
      e_we     = !(kind == 2 && k == 1);
      e_rdn    = !(kind == 3 && k < 2);
      e_wrn    = !(kind == 4 && k == 1);
      e_busdrv = (kind == 2 || kind == 4) && k < 3;
      e_bus    = d;
      e_addr   = {2'b00, a};
      e_res    = (k == len - 1) ? newres : last_res;
      e_valid  = 1'b1;
      cyc();
    end
    e_valid  = 1'b0;
    last_res = newres;
    if (kind == 2) mdl[a] = d;
  endtask

  always @(negedge CLK) begin
    if (e_valid) begin
      chk("stall",    stall_o,  e_stall);
      chk("ram_en_n", ram_en_n, e_en);
      chk("ram_oe_n", ram_oe_n, e_oe);
      chk("ram_we_n", ram_we_n, e_we);
      chk("uart_rdn", uart_rdn, e_rdn);
      chk("uart_wrn", uart_wrn, e_wrn);
      chk("memres",   memres_o, e_res);
      chk("ram_addr", ram_addr, e_addr);
      if (e_busdrv || (e_oe && e_rdn))
        chk("ram_data", ram_data, e_busdrv ? e_bus : 16'h0000);
    end
  end

  // ---------------- directed stimulus ----------------
  int we0, wrn0;
  initial begin
    // reset held with a pending load
    memread_i = 1'b1; addr_i = 16'h1234;
    #12 probe_force = 1'b1;
    #1;
    chk("rst_en",    ram_en_n, 1'b1);
    chk("rst_oe",    ram_oe_n, 1'b1);
    chk("rst_we",    ram_we_n, 1'b1);
    chk("rst_rdn",   uart_rdn, 1'b1);
    chk("rst_wrn",   uart_wrn, 1'b1);
    chk("rst_stall", stall_o,  1'b0);
    chk("rst_res",   memres_o, 16'h0000);
    chk("rst_bus",   ram_data, 16'h0000);
    @(posedge CLK); #1;
    probe_force = 1'b0; memread_i = 1'b0; RST = 1'b1;
    cyc();

    // SRAM read of preloaded word
    memread_i = 1'b1; addr_i = 16'h1234; #1;
    chk("lit_addr",  ram_addr, 18'h01234);
    chk("lit_stall", stall_o,  1'b1);
    access(1, 0, 16'h1234, 16'h0000, 0, 0, 0);
    access(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    chk("lit_beef", memres_o, 16'hBEEF);

    // SRAM write then readback
    we0 = we_cnt;
    access(0, 1, 16'h0040, 16'hA5A5, 0, 0, 0);
    chk("lit_we_pulses", we_cnt - we0, 1);
    access(1, 0, 16'h0040, 16'h0000, 0, 0, 0);
    access(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    chk("lit_a5a5", memres_o, 16'hA5A5);

    // back-to-back accesses, and read+write together (store wins)
    access(1, 0, 16'h0100, 16'h0000, 0, 0, 0);
    access(0, 1, 16'h0101, 16'h1357, 0, 0, 0);
    access(1, 0, 16'h0101, 16'h0000, 0, 0, 0);
    access(1, 1, 16'h0200, 16'h7777, 0, 0, 0);
    access(1, 0, 16'h0200, 16'h0000, 0, 0, 0);
    access(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    chk("lit_7777", memres_o, 16'h7777);

    // UART status read
    memread_i = 1'b1; addr_i = 16'hBF01;
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1; #1;
`ifdef MEM_ACCESS_UART_EN
    chk("lit_stat",       memres_o, 16'h0003);
    chk("lit_stat_stall", stall_o,  1'b0);
`else
    chk("lit_stat_sram_stall", stall_o, 1'b1);
`endif
    access(1, 0, 16'hBF01, 16'h0000, 1, 1, 1);
    access(1, 0, 16'hBF01, 16'h0000, 1, 1, 0);

    // UART data write, then data read
    wrn0 = wrn_cnt;
    access(0, 1, 16'hBF00, 16'h0041, 0, 0, 0);
`ifdef MEM_ACCESS_UART_EN
    chk("lit_wrn_pulses", wrn_cnt - wrn0, 1);
    chk("lit_tx",         uart_tx, 8'h41);
`else
    chk("lit_wrn_pulses", wrn_cnt - wrn0, 0);
    chk("lit_bf00_sram",  sram[16'hBF00], 16'h0041);
`endif
    access(1, 0, 16'hBF00, 16'h0000, 0, 0, 0);
    access(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
`ifdef MEM_ACCESS_UART_EN
    chk("lit_rx", memres_o, 16'h005C);
`else
    chk("lit_rx", memres_o, 16'h0041);
`endif
    access(0, 1, 16'hBF01, 16'hFFFF, 0, 0, 0);
    access(1, 0, 16'h0300, 16'h0000, 0, 0, 0);

    // reset pulled in WR_LO
    memwrite_i = 1'b1; memread_i = 1'b0; addr_i = 16'h0300; wdata_i = 16'h1111;
    cyc();
    chk("wrlo_we", ram_we_n, 1'b0);
    RST = 1'b0; probe_force = 1'b1; #1;
    chk("mid_rst_we",    ram_we_n, 1'b1);
    chk("mid_rst_en",    ram_en_n, 1'b1);
    chk("mid_rst_stall", stall_o,  1'b0);
    chk("mid_rst_bus",   ram_data, 16'h0000);
    memwrite_i = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1; probe_force = 1'b0; last_res = 16'h0000;
    cyc();
    access(1, 0, 16'h0300, 16'h0000, 0, 0, 0);
    access(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    chk("lit_no_partial_wr", memres_o, 16'h0300 ^ 16'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
